rob_retire_queue: RTL and testbench
===================================

ROB_RETIRE_QUEUE -- requirements
Module: rob_retire_queue

Interface
REQ-001 Parameter DEPTH, default 16, entry count; SHALL be a power of two, 4..64.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 flush  input  1  discard all entries.
REQ-005 alloc_valid  input  1  dispatch requests one entry.
REQ-006 alloc_dest_reg  input  5  destination register of allocated entry.
REQ-007 alloc_dest_reg_valid  input  1  entry writes the register file.
REQ-008 alloc_ready  output  1  entry available this cycle.
REQ-009 alloc_tag  output  log2(DEPTH)  index assigned to an accepted allocation (current tail).
REQ-010 complete_valid  input  1  execution result delivery.
REQ-011 complete_tag  input  log2(DEPTH)  entry being completed.
REQ-012 complete_result_lo  input  32  result value.
REQ-013 slot_data  output  rob_entry_t[4]  entries head+0..head+3; fields dest_reg, dest_reg_valid, result_lo populated, all other fields zero.
REQ-014 slot_valid  output  1[4]  slot i is retirable.
REQ-015 empty  output  1  no allocated entries.
REQ-016 consume  input  1  writeback retires entries this cycle.
REQ-017 consume_count  input  2  retire count minus one (0..3 = 1..4 entries).

Function
REQ-018 State: head, tail pointers (log2(DEPTH) bits, wrap modulo DEPTH), occupancy count (log2(DEPTH)+1 bits), per-entry allocated/done flags, dest_reg, dest_reg_valid, result_lo.
REQ-019 alloc_ready SHALL equal (count < DEPTH) from registered state; same-cycle retire does not raise it.
REQ-020 Allocation accepted when alloc_valid & alloc_ready & ~flush: entry[tail] gets allocated=1, done=0, dest fields; tail += 1; visible on slot outputs next cycle.
REQ-021 alloc_valid while alloc_ready=0: ignored, no state change.
REQ-022 Completion when complete_valid & ~flush & entry[complete_tag] allocated & not done: result_lo written, done=1; slot_valid reflects it next cycle.
REQ-023 Completion to unallocated or already-done tag: ignored.
REQ-024 slot_valid[i] = (i < count) & done[head+i] & slot_valid[i-1] (slot 0: no predecessor term); valid slots always form a contiguous prefix.
REQ-025 slot_data[i] SHALL reflect entry head+i (mod DEPTH) combinationally from registered state; contents unspecified when slot_valid[i]=0.
REQ-026 empty SHALL equal (count == 0).
REQ-027 Retire amount R = min(consume_count+1, number of asserted slot_valid) when consume=1, else 0.
REQ-028 On retire: entries head..head+R-1 cleared (allocated=0, done=0); head += R.
REQ-029 count_next = count + accepted_alloc - R; simultaneous alloc and retire allowed in any combination.
REQ-030 consume=1 with slot_valid[0]=0 SHALL retire nothing.
REQ-031 Completion arriving in the same cycle as allocation of the same tag: allocation wins, entry done=0.
REQ-032 flush has priority over alloc, complete, consume: next cycle head=tail=0, count=0, all flags cleared, empty=1.
REQ-033 Latency: any input event affects outputs exactly one cycle later; no combinational path from inputs to outputs.

Reset
REQ-034 reset SHALL have priority over all inputs, including flush.
REQ-035 After reset: head=0, tail=0, count=0, all allocated/done=0, empty=1, alloc_ready=1, alloc_tag=0, slot_valid all 0.
REQ-036 Reset asserted mid-operation SHALL discard all in-flight entries; payload storage need not be reset.

Verification
REQ-037 Reset, then alloc 3 entries (dest 1,2,3), complete tags 2,0 -> slot_valid={1,0,0,0}; complete tag 1 -> next cycle {1,1,1,0}; consume, consume_count=2 -> head=3, empty=1.
REQ-038 Fill DEPTH=16 entries without completion -> alloc_ready=0 after 16th; 17th alloc_valid ignored, alloc_tag stays 0.
REQ-039 Wrap: alloc/retire 14, then alloc 4 (tags 14,15,0,1), complete all, consume_count=3 -> slot_data dest_reg in order, head=2.
REQ-040 Simultaneous: count=16 full, all done, consume_count=0 plus alloc_valid -> alloc refused; next cycle count=15, alloc_ready=1.
REQ-041 consume_count=3 with only 2 slot_valid -> exactly 2 retired; consume with none valid -> no change.
REQ-042 flush with 5 entries and same-cycle alloc, complete, consume -> next cycle empty=1, count=0, alloc_tag=0.

Source files
------------

// File: rtl/rob_retire_queue.sv
// rob_retire_queue: in-order reorder buffer with out-of-order completion and up to 4-wide retire.
// slot_data packs each entry as {dest_reg[37:33], dest_reg_valid[32], result_lo[31:0]}.
module rob_retire_queue #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic                alloc_valid,
    input  logic [4:0]          alloc_dest_reg,
    input  logic                alloc_dest_reg_valid,
    output logic                alloc_ready,
    output logic [AW-1:0]       alloc_tag,
    input  logic                complete_valid,
    input  logic [AW-1:0]       complete_tag,
    input  logic [31:0]         complete_result_lo,
    output logic [3:0][37:0]    slot_data,
    output logic [3:0]          slot_valid,
    output logic                empty,
    input  logic                consume,
    input  logic [1:0]          consume_count
);
    logic [AW-1:0]    head, tail;
    logic [AW:0]      count;
    logic [DEPTH-1:0] alloc_f, done_f;
    logic [4:0]       dest [DEPTH];
    logic             dest_v [DEPTH];
    logic [31:0]      res [DEPTH];
    logic             run, accept;
    logic [2:0]       nvalid, want, ret;

    assign alloc_ready = ~count[AW];
    assign alloc_tag   = tail;
    assign empty       = count == '0;
    assign accept      = alloc_valid & alloc_ready & ~flush;

    // Valid slots are the run of completed entries starting at head.
    always_comb begin
        run = 1'b1;
        slot_valid = '0;
        slot_data = '0;
        for (int i = 0; i < 4; i++) begin
            run = run & (count > (AW+1)'(i)) & done_f[head + AW'(i)];
            slot_valid[i] = run;
            slot_data[i] = {dest[head + AW'(i)], dest_v[head + AW'(i)], res[head + AW'(i)]};
        end
        nvalid = 3'($countones(slot_valid));
        want = {1'b0, consume_count} + 3'd1;
        ret = consume ? (want < nvalid ? want : nvalid) : 3'd0;
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            alloc_f <= '0;
            done_f <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (3'(i) < ret) begin
                    alloc_f[head + AW'(i)] <= 1'b0;
                    done_f[head + AW'(i)] <= 1'b0;
                end
            if (complete_valid && alloc_f[complete_tag] && !done_f[complete_tag]) begin
                res[complete_tag] <= complete_result_lo;
                done_f[complete_tag] <= 1'b1;
            end
            // Allocation is placed last so it overrides a same-cycle completion of the tail tag.
            if (accept) begin
                alloc_f[tail] <= 1'b1;
                done_f[tail] <= 1'b0;
                dest[tail] <= alloc_dest_reg;
                dest_v[tail] <= alloc_dest_reg_valid;
                tail <= tail + 1'b1;
            end
            head <= head + AW'(ret);
            count <= count + (AW+1)'(accept) - (AW+1)'(ret);
        end
    end
endmodule

// File: tb/tb_rob_retire_queue.sv
// tb_rob_retire_queue: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_rob_retire_queue;
    localparam int DEPTH = 16;
    localparam int AW = 4;

    logic clock = 1'b0;
    logic reset = 1'b0, flush = 1'b0, alloc_valid = 1'b0, alloc_dest_reg_valid = 1'b0;
    logic complete_valid = 1'b0, consume = 1'b0;
    logic [4:0] alloc_dest_reg = '0;
    logic [AW-1:0] complete_tag = '0, alloc_tag;
    logic [31:0] complete_result_lo = '0;
    logic [1:0] consume_count = '0;
    logic alloc_ready, empty;
    logic [3:0] slot_valid;
    logic [3:0][37:0] slot_data;
    int total = 0, bad = 0;

    always #5 clock = ~clock;

    rob_retire_queue #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_dest_reg(alloc_dest_reg),
        .alloc_dest_reg_valid(alloc_dest_reg_valid), .alloc_ready(alloc_ready),
        .alloc_tag(alloc_tag), .complete_valid(complete_valid), .complete_tag(complete_tag),
        .complete_result_lo(complete_result_lo), .slot_data(slot_data),
        .slot_valid(slot_valid), .empty(empty), .consume(consume), .consume_count(consume_count)
    );

    // Reference model: the in-flight entries as an ordered queue, oldest first.
    typedef struct {
        int tag;
        logic [4:0] dest;
        logic dv;
        logic done;
        logic [31:0] res;
    } ent_t;
    ent_t q[$];
    int m_tail = 0, m_head = 0;

    function automatic logic [3:0] m_valid();
        logic [3:0] v = '0;
        for (int i = 0; i < 4; i++)
            if (i < q.size() && q[i].done && (i == 0 || v[i-1])) v[i] = 1'b1;
        return v;
    endfunction

    task automatic cyc(input logic rs, input logic f, input logic av, input logic [4:0] ad,
                       input logic adv, input logic cv, input logic [AW-1:0] ct,
                       input logic [31:0] cr, input logic cons, input logic [1:0] cc);
        int nv, r;
        logic rdy;
        reset = rs; flush = f; alloc_valid = av; alloc_dest_reg = ad; alloc_dest_reg_valid = adv;
        complete_valid = cv; complete_tag = ct; complete_result_lo = cr;
        consume = cons; consume_count = cc;
        @(posedge clock);
        if (rs || f) begin
            q.delete();
            m_tail = 0;
            m_head = 0;
        end else begin
            rdy = q.size() < DEPTH;
            nv = $countones(m_valid());
            r = cons ? ((int'(cc) + 1 < nv) ? int'(cc) + 1 : nv) : 0;
            if (cv) foreach (q[k]) if (q[k].tag == int'(ct) && !q[k].done) begin
                q[k].done = 1'b1;
                q[k].res = cr;
            end
            repeat (r) void'(q.pop_front());
            if (av && rdy) begin
                q.push_back('{m_tail, ad, adv, 1'b0, 32'h0});
                m_tail = (m_tail + 1) % DEPTH;
            end
            m_head = (m_head + r) % DEPTH;
        end
        #1;
        reset = 1'b0; flush = 1'b0; alloc_valid = 1'b0; complete_valid = 1'b0; consume = 1'b0;
    endtask

    task automatic do_reset(); cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0); endtask
    task automatic alloc(input logic [4:0] d); cyc(1'b0, 1'b0, 1'b1, d, 1'b1, 1'b0, '0, '0, 1'b0, '0); endtask
    task automatic complete(input logic [AW-1:0] t, input logic [31:0] r); cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, t, r, 1'b0, '0); endtask
    task automatic retire(input logic [1:0] cc); cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, cc); endtask

    task automatic test_reset();
        do_reset();
        total += 4;
        if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
        if (alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", alloc_ready); end
        if (alloc_tag !== 4'd0) begin bad++; $display("FAIL reset_tag got=%0d want=0", alloc_tag); end
        if (slot_valid !== 4'b0000) begin bad++; $display("FAIL reset_slot_valid got=%b want=0000", slot_valid); end
    endtask

    task automatic test_basic();
        do_reset();
        cyc(1'b0, 1'b0, 1'b1, 5'd1, 1'b1, 1'b1, 4'd0, 32'hdead, 1'b0, '0);
        total++;
        if (slot_valid !== 4'b0000) begin bad++; $display("FAIL alloc_beats_complete got=%b want=0000", slot_valid); end
        alloc(5'd2);
        alloc(5'd3);
        complete(4'd2, 32'h22);
        complete(4'd0, 32'h11);
        total++;
        if (slot_valid !== 4'b0001) begin bad++; $display("FAIL basic_prefix got=%b want=0001", slot_valid); end
        complete(4'd1, 32'h33);
        total += 4;
        if (slot_valid !== 4'b0111) begin bad++; $display("FAIL basic_all got=%b want=0111", slot_valid); end
        if (slot_data[0] !== {5'd1, 1'b1, 32'h11}) begin bad++; $display("FAIL basic_slot0 got=%h want=%h", slot_data[0], {5'd1, 1'b1, 32'h11}); end
        if (slot_data[1] !== {5'd2, 1'b1, 32'h33}) begin bad++; $display("FAIL basic_slot1 got=%h want=%h", slot_data[1], {5'd2, 1'b1, 32'h33}); end
        if (slot_data[2] !== {5'd3, 1'b1, 32'h22}) begin bad++; $display("FAIL basic_slot2 got=%h want=%h", slot_data[2], {5'd3, 1'b1, 32'h22}); end
        retire(2'd2);
        total += 2;
        if (empty !== 1'b1) begin bad++; $display("FAIL basic_retire_empty got=%b want=1", empty); end
        if (alloc_tag !== 4'd3) begin bad++; $display("FAIL basic_retire_tag got=%0d want=3", alloc_tag); end
    endtask

    task automatic test_full_and_simul();
        do_reset();
        for (int i = 0; i < DEPTH; i++) alloc(5'(i));
        total += 3;
        if (alloc_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", alloc_ready); end
        if (alloc_tag !== 4'd0) begin bad++; $display("FAIL full_tag got=%0d want=0", alloc_tag); end
        if (empty !== 1'b0) begin bad++; $display("FAIL full_empty got=%b want=0", empty); end
        alloc(5'd31);
        total += 2;
        if (alloc_tag !== 4'd0) begin bad++; $display("FAIL overflow_tag got=%0d want=0", alloc_tag); end
        if (alloc_ready !== 1'b0) begin bad++; $display("FAIL overflow_ready got=%b want=0", alloc_ready); end
        for (int t = 0; t < DEPTH; t++) complete(4'(t), 32'(t * 3));
        total++;
        if (slot_valid !== 4'b1111) begin bad++; $display("FAIL full_done got=%b want=1111", slot_valid); end
        cyc(1'b0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, '0, '0, 1'b1, 2'd0);
        total += 3;
        if (alloc_ready !== 1'b1) begin bad++; $display("FAIL simul_ready got=%b want=1", alloc_ready); end
        if (alloc_tag !== 4'd0) begin bad++; $display("FAIL simul_refused_tag got=%0d want=0", alloc_tag); end
        if (slot_data[0][37:33] !== 5'd1) begin bad++; $display("FAIL simul_head got=%0d want=1", slot_data[0][37:33]); end
        alloc(5'd9);
        total += 2;
        if (alloc_ready !== 1'b0) begin bad++; $display("FAIL refill_ready got=%b want=0", alloc_ready); end
        if (alloc_tag !== 4'd1) begin bad++; $display("FAIL refill_tag got=%0d want=1", alloc_tag); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 14; i++) alloc(5'(i));
        for (int t = 0; t < 14; t++) complete(4'(t), 32'(t));
        for (int k = 0; k < 4; k++) retire(2'd3);
        total += 2;
        if (empty !== 1'b1) begin bad++; $display("FAIL wrap_drain_empty got=%b want=1", empty); end
        if (alloc_tag !== 4'd14) begin bad++; $display("FAIL wrap_drain_tag got=%0d want=14", alloc_tag); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (alloc_tag !== 4'((14 + i) % DEPTH)) begin bad++; $display("FAIL wrap_tag%0d got=%0d want=%0d", i, alloc_tag, (14 + i) % DEPTH); end
            alloc(5'(20 + i));
        end
        complete(4'd14, 32'h1); complete(4'd15, 32'h2); complete(4'd0, 32'h3); complete(4'd1, 32'h4);
        total++;
        if (slot_valid !== 4'b1111) begin bad++; $display("FAIL wrap_valid got=%b want=1111", slot_valid); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (slot_data[i] !== {5'(20 + i), 1'b1, 32'(i + 1)}) begin bad++; $display("FAIL wrap_slot%0d got=%h want=%h", i, slot_data[i], {5'(20 + i), 1'b1, 32'(i + 1)}); end
        end
        retire(2'd3);
        total += 2;
        if (empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b want=1", empty); end
        if (alloc_tag !== 4'd2) begin bad++; $display("FAIL wrap_head_tag got=%0d want=2", alloc_tag); end
    endtask

    task automatic test_partial();
        do_reset();
        alloc(5'd4); alloc(5'd5); alloc(5'd6);
        complete(4'd0, 32'ha); complete(4'd1, 32'hb);
        total++;
        if (slot_valid !== 4'b0011) begin bad++; $display("FAIL partial_pre got=%b want=0011", slot_valid); end
        retire(2'd3);
        total += 2;
        if (slot_valid !== 4'b0000) begin bad++; $display("FAIL partial_after got=%b want=0000", slot_valid); end
        if (empty !== 1'b0) begin bad++; $display("FAIL partial_empty got=%b want=0", empty); end
        complete(4'd2, 32'hc);
        total += 2;
        if (slot_valid !== 4'b0001) begin bad++; $display("FAIL partial_head got=%b want=0001", slot_valid); end
        if (slot_data[0] !== {5'd6, 1'b1, 32'hc}) begin bad++; $display("FAIL partial_slot0 got=%h want=%h", slot_data[0], {5'd6, 1'b1, 32'hc}); end
        do_reset();
        alloc(5'd7); alloc(5'd8);
        retire(2'd3);
        total += 2;
        if (empty !== 1'b0) begin bad++; $display("FAIL none_valid_empty got=%b want=0", empty); end
        if (alloc_tag !== 4'd2) begin bad++; $display("FAIL none_valid_tag got=%0d want=2", alloc_tag); end
        complete(4'd0, 32'hd);
        total++;
        if (slot_valid !== 4'b0001) begin bad++; $display("FAIL none_valid_head got=%b want=0001", slot_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) alloc(5'(i + 1));
        complete(4'd0, 32'h5);
        cyc(1'b0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 4'd1, 32'h6, 1'b1, 2'd3);
        total += 4;
        if (empty !== 1'b1) begin bad++; $display("FAIL flush_empty got=%b want=1", empty); end
        if (alloc_tag !== 4'd0) begin bad++; $display("FAIL flush_tag got=%0d want=0", alloc_tag); end
        if (alloc_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b want=1", alloc_ready); end
        if (slot_valid !== 4'b0000) begin bad++; $display("FAIL flush_valid got=%b want=0000", slot_valid); end
        alloc(5'd8);
        complete(4'd0, 32'h9);
        total += 2;
        if (slot_valid !== 4'b0001) begin bad++; $display("FAIL flush_realloc got=%b want=0001", slot_valid); end
        if (slot_data[0][37:33] !== 5'd8) begin bad++; $display("FAIL flush_realloc_dest got=%0d want=8", slot_data[0][37:33]); end
        alloc(5'd3); alloc(5'd4);
        cyc(1'b1, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, '0, '0, 1'b0, '0);
        total += 2;
        if (empty !== 1'b1) begin bad++; $display("FAIL midreset_empty got=%b want=1", empty); end
        if (alloc_tag !== 4'd0) begin bad++; $display("FAIL midreset_tag got=%0d want=0", alloc_tag); end
    endtask

    task automatic test_random();
        logic [3:0] mv;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 99) == 0, $urandom_range(0, 99) < 60,
                5'($urandom), 1'($urandom), $urandom_range(0, 99) < 55,
                4'((m_head + $urandom_range(0, q.size())) % DEPTH), $urandom,
                $urandom_range(0, 99) < 40, 2'($urandom));
            mv = m_valid();
            total += 4;
            if (alloc_ready !== (q.size() < DEPTH)) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", n, alloc_ready, q.size() < DEPTH); end
            if (alloc_tag !== 4'(m_tail)) begin bad++; $display("FAIL rnd_tag cyc=%0d got=%0d want=%0d", n, alloc_tag, m_tail); end
            if (empty !== (q.size() == 0)) begin bad++; $display("FAIL rnd_empty cyc=%0d got=%b want=%b", n, empty, q.size() == 0); end
            if (slot_valid !== mv) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", n, slot_valid, mv); end
            for (int i = 0; i < 4; i++) if (mv[i]) begin
                total++;
                if (slot_data[i] !== {q[i].dest, q[i].dv, q[i].res}) begin bad++; $display("FAIL rnd_slot%0d cyc=%0d got=%h want=%h", i, n, slot_data[i], {q[i].dest, q[i].dv, q[i].res}); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_and_simul();
        test_wrap();
        test_partial();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
